// File: rtl/rr_mux2_pkg.sv
// Shared select encodings and types for the round-robin two-channel mux stage.
package rr_mux2_pkg;
   typedef logic sel_t;

   localparam sel_t SEL_D0 = 1'b0;
   localparam sel_t SEL_D1 = 1'b1;

   function automatic sel_t other_sel(input sel_t s);
      return (s == SEL_D0) ? SEL_D1 : SEL_D0;
   endfunction
endpackage

// File: rtl/rr_mux2_stage_mux.sv
// Plain N-bit two-input datapath multiplexer.
module Mux2to1 #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_d0,
   input  logic [N-1:0] i_d1,
   input  logic         i_sel,
   output logic [N-1:0] o_y
);
   assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/rr_mux2_stage.sv
// Two-channel round-robin arbiter feeding a one-entry registered output.
// Define RR_MUX2_PKT_LOCK_EN to hold the grant across multi-beat packets.
module rr_mux2_stage
   import rr_mux2_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d0,
   input  logic         v0,
   output logic         r0,
   input  logic [N-1:0] d1,
   input  logic         v1,
   output logic         r1,
`ifdef RR_MUX2_PKT_LOCK_EN
   input  logic         l0,
   input  logic         l1,
`endif
   output logic         s,
   output logic [N-1:0] y,
   output logic         yv,
   input  logic         yr
);
   logic [N-1:0] r_y;
   logic         r_yv;
   sel_t         r_p;
   sel_t         w_arb;
   logic         w_space;
   logic         w_acc;
   logic [N-1:0] w_mux;

   assign w_space = !r_yv || yr;

   always_comb begin
      w_arb = r_p;
      unique case (1'b1)
         (v0 && !v1): w_arb = SEL_D0;
         (v1 && !v0): w_arb = SEL_D1;
         default: ;
      endcase
   end

`ifdef RR_MUX2_PKT_LOCK_EN
   logic r_lock;
   sel_t r_lock_ch;
   logic w_last;

   assign s      = r_lock ? r_lock_ch : w_arb;
   assign w_last = (s == SEL_D1) ? l1 : l0;
`else
   assign s = w_arb;
`endif

   assign r0    = w_space && (s == SEL_D0);
   assign r1    = w_space && (s == SEL_D1);
   assign w_acc = (v0 && r0) || (v1 && r1);

   Mux2to1 #(.N(N)) u_mux (
      .i_d0  (d0),
      .i_d1  (d1),
      .i_sel (s),
      .o_y   (w_mux)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_y  <= '0;
         r_yv <= 1'b0;
         r_p  <= SEL_D0;
      end else if (w_acc) begin
         r_y  <= w_mux;
         r_yv <= 1'b1;
`ifdef RR_MUX2_PKT_LOCK_EN
         if (w_last) r_p <= other_sel(s);
`else
         r_p  <= other_sel(s);
`endif
      end else if (yr) begin
         r_yv <= 1'b0;
      end
   end

`ifdef RR_MUX2_PKT_LOCK_EN
   // Grant stays with the sending channel until its last beat goes through.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock    <= 1'b0;
         r_lock_ch <= SEL_D0;
      end else if (w_acc) begin
         r_lock    <= !w_last;
         r_lock_ch <= s;
      end
   end
`endif

   assign y  = r_y;
   assign yv = r_yv;
endmodule

// File: tb/tb_rr_mux2_stage.sv
// Directed vector bench for rr_mux2_stage at N=4 and N=8.
module tb_rr_mux2_stage;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] d0, d1;
   logic       v0, v1, yr;
   logic       s4, r04, r14, yv4;
   logic [3:0] y4;
   logic       s8, r08, r18, yv8;
   logic [7:0] y8;
`ifdef RR_MUX2_PKT_LOCK_EN
   logic       l0, l1;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rr_mux2_stage #(.N(4)) u4 (
      .clk(clk), .reset(reset),
      .d0(d0[3:0]), .v0(v0), .r0(r04),
      .d1(d1[3:0]), .v1(v1), .r1(r14),
`ifdef RR_MUX2_PKT_LOCK_EN
      .l0(l0), .l1(l1),
`endif
      .s(s4), .y(y4), .yv(yv4), .yr(yr)
   );

   rr_mux2_stage #(.N(8)) u8 (
      .clk(clk), .reset(reset),
      .d0(d0), .v0(v0), .r0(r08),
      .d1(d1), .v1(v1), .r1(r18),
`ifdef RR_MUX2_PKT_LOCK_EN
      .l0(l0), .l1(l1),
`endif
      .s(s8), .y(y8), .yv(yv8), .yr(yr)
   );

   typedef struct {
      logic       rst;
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       yr;
      logic       chk_comb;
      logic       s;
      logic       r0;
      logic       r1;
      logic [7:0] y;
      logic       yv;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic chk_comb(input string tag, input logic es,
                           input logic er0, input logic er1);
      chk({tag, " s4"},  {7'd0, s4},  {7'd0, es});
      chk({tag, " r04"}, {7'd0, r04}, {7'd0, er0});
      chk({tag, " r14"}, {7'd0, r14}, {7'd0, er1});
      chk({tag, " s8"},  {7'd0, s8},  {7'd0, es});
      chk({tag, " r08"}, {7'd0, r08}, {7'd0, er0});
      chk({tag, " r18"}, {7'd0, r18}, {7'd0, er1});
      chk({tag, " excl"}, {7'd0, r08 && r18}, 8'd0);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] ey,
                          input logic eyv);
      chk({tag, " y4"},  {4'd0, y4},  {4'd0, ey[3:0]});
      chk({tag, " yv4"}, {7'd0, yv4}, {7'd0, eyv});
      chk({tag, " y8"},  y8,          ey);
      chk({tag, " yv8"}, {7'd0, yv8}, {7'd0, eyv});
   endtask

   function automatic vec_t mk(input logic rst, input logic a0,
                               input logic [7:0] x0, input logic a1,
                               input logic [7:0] x1, input logic ryr,
                               input logic cc, input logic es,
                               input logic er0, input logic er1,
                               input logic [7:0] ey, input logic eyv);
      vec_t v;
      v.rst = rst; v.v0 = a0; v.d0 = x0; v.v1 = a1; v.d1 = x1;
      v.yr = ryr; v.chk_comb = cc; v.s = es; v.r0 = er0; v.r1 = er1;
      v.y = ey; v.yv = eyv;
      return v;
   endfunction

   initial begin
      reset = 1'b1; v0 = 0; v1 = 0; d0 = 0; d1 = 0; yr = 0;
`ifdef RR_MUX2_PKT_LOCK_EN
      l0 = 1'b1; l1 = 1'b1;
`endif
      //          rst v0 d0    v1 d1    yr cc s  r0 r1 y      yv
      tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
      tbl[1]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0);
      tbl[2]  = mk(0, 1, 8'h0C, 0, 8'h00, 1, 1, 0, 1, 0, 8'h0C, 1);
      tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0, 8'h0C, 1);
      tbl[4]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 1, 8'h0C, 0);
      tbl[5]  = mk(0, 0, 8'h00, 1, 8'h33, 1, 1, 1, 0, 1, 8'h33, 1);
      tbl[6]  = mk(0, 1, 8'hFF, 1, 8'h7F, 1, 1, 0, 1, 0, 8'hFF, 1);
      tbl[7]  = mk(0, 1, 8'hFF, 1, 8'h7F, 1, 1, 1, 0, 1, 8'h7F, 1);
      tbl[8]  = mk(0, 1, 8'hFF, 1, 8'h7F, 1, 1, 0, 1, 0, 8'hFF, 1);
      tbl[9]  = mk(0, 1, 8'hFF, 1, 8'h7F, 1, 1, 1, 0, 1, 8'h7F, 1);
      tbl[10] = mk(0, 1, 8'h05, 0, 8'h00, 1, 1, 0, 1, 0, 8'h05, 1);
      tbl[11] = mk(0, 1, 8'h0A, 0, 8'h00, 0, 1, 0, 0, 0, 8'h05, 1);
      tbl[12] = mk(0, 1, 8'h0B, 0, 8'h00, 0, 1, 0, 0, 0, 8'h05, 1);
      tbl[13] = mk(0, 1, 8'h0C, 0, 8'h00, 0, 1, 0, 0, 0, 8'h05, 1);
      tbl[14] = mk(0, 1, 8'h0D, 0, 8'h00, 1, 1, 0, 1, 0, 8'h0D, 1);
      tbl[15] = mk(0, 0, 8'h00, 1, 8'h0E, 1, 1, 1, 0, 1, 8'h0E, 1);
      tbl[16] = mk(0, 1, 8'h06, 0, 8'h00, 0, 1, 0, 0, 0, 8'h0E, 1);
      tbl[17] = mk(1, 1, 8'h06, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0);
      tbl[18] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0);
      tbl[19] = mk(0, 1, 8'h01, 1, 8'h02, 1, 1, 0, 1, 0, 8'h01, 1);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         reset = tbl[i].rst; v0 = tbl[i].v0; d0 = tbl[i].d0;
         v1 = tbl[i].v1; d1 = tbl[i].d1; yr = tbl[i].yr;
         #1;
         if (tbl[i].chk_comb)
            chk_comb($sformatf("v%0d", i), tbl[i].s, tbl[i].r0, tbl[i].r1);
         @(posedge clk); #1;
         chk_out($sformatf("v%0d", i), tbl[i].y, tbl[i].yv);
      end

      // Stall then release: wait for the held ch1 beat to move on.
      @(negedge clk);
      reset = 1'b1; v0 = 0; v1 = 0; yr = 0;
      @(negedge clk);
      reset = 1'b0; v1 = 1; d1 = 8'h42;
      @(posedge clk); #1;
      chk_out("h_load", 8'h42, 1'b1);
      @(negedge clk);
      d1 = 8'h43;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk_comb($sformatf("h_stall%0d", k), 1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end
      yr = 1'b1;
      begin
         int waited = 0;
         while (y8 !== 8'h43 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
         end
         chk("h_release_wait", {7'd0, waited < 8}, 8'd1);
         chk_out("h_release", 8'h43, 1'b1);
      end

`ifdef RR_MUX2_PKT_LOCK_EN
      // Three-beat ch0 packet while ch1 stays valid.
      @(negedge clk);
      reset = 1'b1; v0 = 0; v1 = 0; yr = 1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         v0 = (k < 3); v1 = 1'b1;
         d0 = 8'h11 + 8'(k); d1 = 8'h99;
         l0 = (k == 2); l1 = 1'b1;
         #1;
         chk_comb($sformatf("pkt%0d", k), (k == 3), (k < 3), (k == 3));
         @(posedge clk); #1;
         chk_out($sformatf("pkt%0d", k), (k < 3) ? 8'h11 + 8'(k) : 8'h99,
                 1'b1);
         @(negedge clk);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_mux2_stage.md
RR_MUX2_STAGE -- requirements
Module: rr_mux2_stage

Interface
REQ-001 SHALL have parameter N, default 4, meaning data width of each input channel and of the output.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port d0, input, N bits: channel 0 data.
REQ-005 SHALL have port v0, input, 1 bit: channel 0 valid.
REQ-006 SHALL have port r0, output, 1 bit: channel 0 ready.
REQ-007 SHALL have port d1, input, N bits: channel 1 data.
REQ-008 SHALL have port v1, input, 1 bit: channel 1 valid.
REQ-009 SHALL have port r1, output, 1 bit: channel 1 ready.
REQ-010 SHALL have port s, output, 1 bit: current mux select (0 = d0, 1 = d1), combinational.
REQ-011 SHALL have port y, output, N bits: registered output data.
REQ-012 SHALL have port yv, output, 1 bit: output valid.
REQ-013 SHALL have port yr, input, 1 bit: downstream ready.

Function
REQ-014 SHALL transfer a beat on channel i when vi && ri, and on the output when yv && yr.
REQ-015 SHALL hold a one-entry output register; y/yv SHALL be loaded the cycle after an input transfer (latency 1).
REQ-016 SHALL define space = !yv || yr; input acceptance is allowed only when space is 1, so full throughput is one beat per cycle.
REQ-017 SHALL compute s combinationally: only v0 -> 0; only v1 -> 1; both -> priority pointer p; neither -> p.
REQ-018 SHALL drive r0 = space && (s == 0) and r1 = space && (s == 1); never both high.
REQ-019 SHALL set p to the complement of s after every accepted input beat; p SHALL be unchanged when no beat is accepted.
REQ-020 SHALL leave y and yv unchanged while yv && !yr (stall); vi/di may change without effect on y.
REQ-021 SHALL clear yv when the output is taken and no input is accepted in the same cycle.
REQ-022 SHALL, on simultaneous output take and input accept, load the new beat and keep yv = 1 (no bubble).

Reset
REQ-023 SHALL, while reset is high, force yv = 0, y = 0, p = 0 at the next clock edge, overriding any transfer in that cycle.
REQ-024 SHALL drop a beat held mid-stall on reset; r0/r1 SHALL follow REQ-018 from the reset state.

Configuration
REQ-025 SHALL support macro RR_MUX2_PKT_LOCK_EN: when defined, add 1-bit inputs l0/l1 (last-beat flags); after a non-last beat from channel i, s SHALL stay at i until that channel's last beat is accepted, and p SHALL update only on last beats.
REQ-026 SHALL, without RR_MUX2_PKT_LOCK_EN, omit l0/l1 and arbitrate per beat per REQ-017/019.

Structure
REQ-027 SHALL take constant SEL_D0 = 1'b0, SEL_D1 = 1'b1 and typedef sel_t from shared package rr_mux2_pkg.
REQ-028 SHALL instantiate the existing Mux2to1 #(.N(N)) sub-module for the datapath, driven by s.

Verification
REQ-029 Bench SHALL cover: N=4, v0=1 d0=4'hC, v1=0, yr=1 -> r0=1, next cycle y=4'hC yv=1, p=1.
REQ-030 Bench SHALL cover: both valid continuously, d0=8'd255, d1=8'd127, yr=1 -> y alternates 255,127,255,127 with yv held 1.
REQ-031 Bench SHALL cover: yv=1 y=4'h5, yr=0 for 3 cycles with v0=1 -> r0=r1=0, y stays 4'h5; yr=1 -> next beat loads.
REQ-032 Bench SHALL cover: reset asserted during stall with yv=1 -> next edge yv=0, y=0, p=0.
REQ-033 Bench SHALL cover (RR_MUX2_PKT_LOCK_EN): channel 0 sends 3 beats l0=0,0,1 while v1=1 -> three ch0 beats, then ch1.
